// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   Opcode constants (4-bit, 0 = no-op), FSM state encoding, and
//   small opcode-classification helpers used by mdu_arith and mdu_ctrl.
package mdu_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Multi-cycle ops: the ones that occupy the unit and raise busy.
    function automatic logic is_long(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || is_div(op);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath for MULT/MULTU/DIV/DIVU.
// Ports:
//   A, B     in  32  rs / rt operands
//   op       in  4   MDU opcode
//   res_hi   out 32  HI result (product high word or remainder)
//   res_lo   out 32  LO result (product low word or quotient)
//   div_zero out 1   divide op with B == 0; result must not be committed
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        [31:0] ub;
    logic               ovf;

    assign div_zero = is_div(op) && (B == 32'd0);

    // Divisor forced to 1 on divide-by-zero so the dividers never see 0.
    assign ub  = (B == 32'd0) ? 32'd1 : B;
    assign sa  = $signed(A);
    assign sb  = $signed(ub);
    // The one signed quotient that does not fit in 32 bits.
    assign ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV: begin
                if (ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    // SV signed / and % truncate toward zero; remainder
                    // takes the dividend's sign.
                    res_hi = 32'(sa % sb);
                    res_lo = 32'(sa / sb);
                end
            end
            MDU_DIVU: begin
                res_hi = A % ub;
                res_lo = A / ub;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS E-stage multiply/divide controller with HI/LO registers.
// Ports:
//   clk      in  1   system clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   start    in  1   E-stage instruction is an MDU op (one cycle per instr)
//   op       in  4   MDU opcode (mdu_pkg constants)
//   A, B     in  32  rs / rt operands
//   busy     out 1   registered; multi-cycle op in flight
//   hi, lo   out 32  registered HI/LO architectural registers
//   mf_out   out 32  combinational MFHI/MFLO read data, else 0
//
// state  | meaning
// S_IDLE | accepts new ops; MTHI/MTLO write directly
// S_RUN  | counting down latency; result held in p_hi/p_lo, start ignored
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_out
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    mdu_state_t  state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_dz;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    mdu_arith u_arith (
        .A        (A),
        .B        (B),
        .op       (op),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_dz  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_long(op)) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            cnt   <= is_div(op) ? DIV_LOAD : MUL_LOAD;
                            p_hi  <= res_hi;
                            p_lo  <= res_lo;
                            p_dz  <= div_zero;
                        end else if (op == MDU_MTHI) begin
                            hi <= A;
                        end else if (op == MDU_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt == 4'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        // Divide-by-zero burns the latency but leaves HI/LO alone.
                        if (!p_dz) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mf_out = 32'd0;
        if (op == MDU_MFHI)      mf_out = hi;
        else if (op == MDU_MFLO) mf_out = lo;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .mf_out (mf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; returns in the cycle after issue.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        op    = MDU_NOP;
    endtask

    // Counts consecutive busy cycles from now; bounded so a stuck busy shows up as a wrong count.
    task automatic busy_len(output int cnt);
        cnt = 0;
        for (int i = 0; i < 30 && busy === 1'b1; i++) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = MDU_NOP;
        A     = 32'd0;
        B     = 32'd0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_mf", mf_out, 32'd0);
        rst_n = 1'b1;
        tick();

        // MTHI / MTLO / MFHI / MFLO
        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(MDU_MTLO, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi", hi, 32'h1234_5678);
        op = MDU_MFHI; #1;
        check("mfhi", mf_out, 32'h1234_5678);
        op = MDU_MFLO; #1;
        check("mflo", mf_out, 32'h9ABC_DEF0);
        op = MDU_NOP; #1;
        check("mf_nop", mf_out, 32'd0);

        // MULT -2 * 3
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_hold", hi, 32'h1234_5678);
        busy_len(n);
        check("mult_len", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU same operands
        issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
        busy_len(n);
        check("multu_len", n, 32'd5);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        busy_len(n);
        check("div_len", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2: remainder follows the dividend sign
        issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
        busy_len(n);
        check("divn_lo", lo, 32'hFFFF_FFFD);
        check("divn_hi", hi, 32'd1);

        // DIVU 7 / 2
        issue(MDU_DIVU, 32'd7, 32'd2);
        busy_len(n);
        check("divu_len", n, 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // Signed overflow case
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // Divide by zero keeps HI/LO
        issue(MDU_MTHI, 32'h11, 32'd0);
        issue(MDU_MTLO, 32'h22, 32'd0);
        issue(MDU_DIV, 32'd99, 32'd0);
        busy_len(n);
        check("dz_len", n, 32'd10);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        // MTLO during busy cycle 3 is ignored
        issue(MDU_MULT, 32'd6, 32'd7);
        tick();
        tick();
        check("ign_busy3", {31'd0, busy}, 32'd1);
        issue(MDU_MTLO, 32'hDEAD_BEEF, 32'd0);
        busy_len(n);
        check("ign_len", n + 3, 32'd5);
        check("ign_lo", lo, 32'd42);
        check("ign_hi", hi, 32'd0);

        // DIV in first non-busy cycle
        issue(MDU_DIV, 32'd100, 32'd7);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        busy_len(n);
        check("b2b_len", n, 32'd10);
        check("b2b_lo", lo, 32'd14);
        check("b2b_hi", hi, 32'd2);

        // Undefined op: no state change
        issue(4'hF, 32'hFFFF_FFFF, 32'd1);
        check("undef_busy", {31'd0, busy}, 32'd0);
        check("undef_hi", hi, 32'd2);
        check("undef_lo", lo, 32'd14);

        // Reset during DIVU busy cycle 4
        issue(MDU_DIVU, 32'd1000, 32'd3);
        tick();
        tick();
        tick();
        check("rr_busy4", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rr_busy", {31'd0, busy}, 32'd0);
        check("rr_hi", hi, 32'd0);
        check("rr_lo", lo, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("rr_busy_after", {31'd0, busy}, 32'd0);
        check("rr_hi_after", hi, 32'd0);
        check("rr_lo_after", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
